// File: rtl/hazard_sb_pkg.sv
// hazard_pkg: shared constants for the hazard_sb pipeline hazard controller.
//   - forward-select encodings for the E-stage ALU operand muxes
//   - MDU sequencer state encodings
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/hazard_sb_if.sv
// hazard_sb_if: pipeline-to-hazard-unit bundle.
//   Datapath side (master) drives register addresses, write/load flags,
//   MDU start, HI/LO access flags and the M-stage exception.
//   Hazard side (slave) drives forward selects, per-stage stall/flush and
//   MDU status (busy, done pulse, abort pulse).
interface hazard_sb_if #(
    parameter int RA_W = 5
);
    logic [RA_W-1:0] rsD, rtD;
    logic            branchD, hilo_readD;
    logic [RA_W-1:0] rsE, rtE, writeregE;
    logic            regwriteE, memtoregE, mdu_startE, hilo_writeE;
    logic [RA_W-1:0] writeregM, writeregW;
    logic            regwriteM, memtoregM, hilo_writeM, regwriteW;
    logic            excM;

    logic            forwardaD, forwardbD;
    logic [1:0]      forwardaE, forwardbE;
    logic            stallF, stallD, stallE, stallM, stallW;
    logic            flushF, flushD, flushE, flushM, flushW;
    logic            mdu_busy, mdu_done, mdu_abort;

    modport master (
        output rsD, rtD, branchD, hilo_readD,
        output rsE, rtE, writeregE, regwriteE, memtoregE, mdu_startE, hilo_writeE,
        output writeregM, writeregW, regwriteM, memtoregM, hilo_writeM, regwriteW,
        output excM,
        input  forwardaD, forwardbD, forwardaE, forwardbE,
        input  stallF, stallD, stallE, stallM, stallW,
        input  flushF, flushD, flushE, flushM, flushW,
        input  mdu_busy, mdu_done, mdu_abort
    );

    modport slave (
        input  rsD, rtD, branchD, hilo_readD,
        input  rsE, rtE, writeregE, regwriteE, memtoregE, mdu_startE, hilo_writeE,
        input  writeregM, writeregW, regwriteM, memtoregM, hilo_writeM, regwriteW,
        input  excM,
        output forwardaD, forwardbD, forwardaE, forwardbE,
        output stallF, stallD, stallE, stallM, stallW,
        output flushF, flushD, flushE, flushM, flushW,
        output mdu_busy, mdu_done, mdu_abort
    );
endinterface

// File: rtl/hazard_sb_mdu_seq.sv
// hazard_mdu_seq: multi-cycle mult/div sequencer.
//   clk, resetn   : clock, synchronous active-low reset
//   start         : mult/div op present in E
//   exc           : exception committed in M (cancels the op)
//   mdu_stall     : freeze request, MDU_CYCLES cycles per op
//   mdu_busy      : state is not IDLE
//   mdu_done      : one-cycle pulse, high during DONE
//   mdu_abort     : one-cycle pulse the cycle after an exception cancels an op
//
//   state | meaning
//   IDLE  | no op; a start here is the first stall cycle
//   BUSY  | counting remaining stall cycles down to zero
//   DONE  | result valid, E advances; start ignored (same op still in E)
module hazard_mdu_seq
    import hazard_pkg::*;
#(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic exc,
    output logic mdu_stall,
    output logic mdu_busy,
    output logic mdu_done,
    output logic mdu_abort
);

    // The IDLE start cycle is stall #1, so BUSY covers the remaining MDU_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 2);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        if (exc) begin
            state_d = IDLE;
            cnt_d   = '0;
            abort_d = (state_q != IDLE);
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign mdu_stall = ((state_q == IDLE) && start) || (state_q == BUSY);
    assign mdu_busy  = (state_q != IDLE);
    assign mdu_done  = done_q;
    assign mdu_abort = abort_q;

endmodule

// File: rtl/hazard_sb.sv
// hazard_sb: hazard/forwarding controller for the 5-stage F/D/E/M/W pipeline.
//   clk, resetn : clock, synchronous active-low reset
//   hz (slave)  : pipeline bundle, see hazard_sb_if
//   HAZARD_PERF_EN adds perf_lw_cnt / perf_br_cnt / perf_mdu_cnt, saturating
//   32-bit counts of cycles with load-use, branch and MDU stalls.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int RA_W       = 5,
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              resetn,
    hazard_sb_if.slave        hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_lw_cnt,
    output logic [31:0]       perf_br_cnt,
    output logic [31:0]       perf_mdu_cnt
`endif
);

    logic mdu_stall, lwstall, brstall, hilostall;

    // Register 0 is hard-zero: a write to it is never a real producer.
    function automatic logic hit(logic [RA_W-1:0] src, logic [RA_W-1:0] dst, logic we);
        return we && (dst != '0) && (src == dst);
    endfunction

    hazard_mdu_seq #(
        .MDU_CYCLES (MDU_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mdu (
        .clk       (clk),
        .resetn    (resetn),
        .start     (hz.mdu_startE),
        .exc       (hz.excM),
        .mdu_stall (mdu_stall),
        .mdu_busy  (hz.mdu_busy),
        .mdu_done  (hz.mdu_done),
        .mdu_abort (hz.mdu_abort)
    );

    always_comb begin
        lwstall = hit(hz.rsD, hz.writeregE, hz.memtoregE) |
                  hit(hz.rtD, hz.writeregE, hz.memtoregE);
        brstall = hz.branchD & (hit(hz.rsD, hz.writeregE, hz.regwriteE) |
                                hit(hz.rtD, hz.writeregE, hz.regwriteE) |
                                hit(hz.rsD, hz.writeregM, hz.memtoregM) |
                                hit(hz.rtD, hz.writeregM, hz.memtoregM));
        hilostall = hz.hilo_readD & (hz.hilo_writeE | hz.hilo_writeM | mdu_stall);

        hz.forwardaD = hit(hz.rsD, hz.writeregM, hz.regwriteM);
        hz.forwardbD = hit(hz.rtD, hz.writeregM, hz.regwriteM);
        hz.forwardaE = hit(hz.rsE, hz.writeregM, hz.regwriteM) ? FWD_M :
                       hit(hz.rsE, hz.writeregW, hz.regwriteW) ? FWD_W : FWD_REG;
        hz.forwardbE = hit(hz.rtE, hz.writeregM, hz.regwriteM) ? FWD_M :
                       hit(hz.rtE, hz.writeregW, hz.regwriteW) ? FWD_W : FWD_REG;

        hz.stallF = lwstall | brstall | hilostall | mdu_stall;
        hz.stallD = hz.stallF;
        hz.stallE = mdu_stall;
        hz.stallM = mdu_stall;
        hz.stallW = mdu_stall;
        // While the MDU freezes E, a bubble would destroy the op sitting there.
        hz.flushE = (lwstall | brstall | hilostall) & ~mdu_stall;
        hz.flushF = 1'b0;
        hz.flushD = 1'b0;
        hz.flushM = 1'b0;
        hz.flushW = 1'b0;

        if (hz.excM) begin
            hz.stallF = 1'b0;
            hz.stallD = 1'b0;
            hz.stallE = 1'b0;
            hz.stallM = 1'b0;
            hz.stallW = 1'b0;
            hz.flushF = 1'b1;
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
            hz.flushM = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lw_q, perf_lw_d;
    logic [31:0] perf_br_q, perf_br_d;
    logic [31:0] perf_mdu_q, perf_mdu_d;

    always_comb begin
        perf_lw_d  = (lwstall   && perf_lw_q  != 32'hFFFF_FFFF) ? perf_lw_q  + 32'd1 : perf_lw_q;
        perf_br_d  = (brstall   && perf_br_q  != 32'hFFFF_FFFF) ? perf_br_q  + 32'd1 : perf_br_q;
        perf_mdu_d = (mdu_stall && perf_mdu_q != 32'hFFFF_FFFF) ? perf_mdu_q + 32'd1 : perf_mdu_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_lw_q  <= '0;
            perf_br_q  <= '0;
            perf_mdu_q <= '0;
        end else begin
            perf_lw_q  <= perf_lw_d;
            perf_br_q  <= perf_br_d;
            perf_mdu_q <= perf_mdu_d;
        end
    end

    assign perf_lw_cnt  = perf_lw_q;
    assign perf_br_cnt  = perf_br_q;
    assign perf_mdu_cnt = perf_mdu_q;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    hazard_sb_if #(.RA_W(5)) hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_lw_cnt, perf_br_cnt, perf_mdu_cnt;
`endif

    hazard_sb #(
        .RA_W       (5),
        .MDU_CYCLES (4),
        .CNT_W      (3)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (hz.slave)
`ifdef HAZARD_PERF_EN
        ,
        .perf_lw_cnt  (perf_lw_cnt),
        .perf_br_cnt  (perf_br_cnt),
        .perf_mdu_cnt (perf_mdu_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        hz.rsD = '0; hz.rtD = '0; hz.branchD = 0; hz.hilo_readD = 0;
        hz.rsE = '0; hz.rtE = '0; hz.writeregE = '0;
        hz.regwriteE = 0; hz.memtoregE = 0; hz.mdu_startE = 0; hz.hilo_writeE = 0;
        hz.writeregM = '0; hz.writeregW = '0;
        hz.regwriteM = 0; hz.memtoregM = 0; hz.hilo_writeM = 0; hz.regwriteW = 0;
        hz.excM = 0;
    endtask

    task automatic chk_stalls(input string tag, input logic fd, input logic emw);
        chk({tag, "_stallF"}, 32'(hz.stallF), 32'(fd));
        chk({tag, "_stallD"}, 32'(hz.stallD), 32'(fd));
        chk({tag, "_stallE"}, 32'(hz.stallE), 32'(emw));
        chk({tag, "_stallM"}, 32'(hz.stallM), 32'(emw));
        chk({tag, "_stallW"}, 32'(hz.stallW), 32'(emw));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();

        // Reset state
        #1;
        chk("rst_busy",  32'(hz.mdu_busy),  32'd0);
        chk("rst_done",  32'(hz.mdu_done),  32'd0);
        chk("rst_abort", 32'(hz.mdu_abort), 32'd0);
        chk_stalls("rst", 1'b0, 1'b0);
        chk("rst_flushE", 32'(hz.flushE), 32'd0);
`ifdef HAZARD_PERF_EN
        chk("rst_perf_lw",  perf_lw_cnt,  32'd0);
        chk("rst_perf_br",  perf_br_cnt,  32'd0);
        chk("rst_perf_mdu", perf_mdu_cnt, 32'd0);
`endif
        resetn = 1'b1;
        tick();

        // E-stage forwarding: M over W, W alone, register 0 never forwarded
        hz.rsE = 5; hz.writeregM = 5; hz.regwriteM = 1; hz.writeregW = 5; hz.regwriteW = 1;
        #1 chk("fwdaE_M", 32'(hz.forwardaE), 32'b10);
        hz.regwriteM = 0;
        #1 chk("fwdaE_W", 32'(hz.forwardaE), 32'b01);
        hz.rsE = 0;
        #1 chk("fwdaE_zero", 32'(hz.forwardaE), 32'b00);
        hz.rtE = 5; hz.regwriteM = 1;
        #1 chk("fwdbE_M", 32'(hz.forwardbE), 32'b10);
        hz.writeregM = 6;
        #1 chk("fwdbE_W", 32'(hz.forwardbE), 32'b01);
        hz.regwriteW = 0;
        #1 chk("fwdbE_none", 32'(hz.forwardbE), 32'b00);

        // D-stage forwarding
        clear_inputs();
        hz.rsD = 7; hz.rtD = 9; hz.writeregM = 7; hz.regwriteM = 1;
        #1 chk("fwdaD_hit", 32'(hz.forwardaD), 32'd1);
        chk("fwdbD_miss", 32'(hz.forwardbD), 32'd0);
        hz.writeregM = 9;
        #1 chk("fwdbD_hit", 32'(hz.forwardbD), 32'd1);
        hz.rtD = 0; hz.writeregM = 0;
        #1 chk("fwdbD_zero", 32'(hz.forwardbD), 32'd0);

        // Load-use stall for one cycle, then the load has left E
        clear_inputs();
        hz.memtoregE = 1; hz.writeregE = 8; hz.rsD = 8;
        #1 chk_stalls("lw", 1'b1, 1'b0);
        chk("lw_flushE", 32'(hz.flushE), 32'd1);
        tick();
        hz.memtoregE = 0; hz.writeregE = 0;
        #1 chk_stalls("lw_after", 1'b0, 1'b0);
        chk("lw_after_flushE", 32'(hz.flushE), 32'd0);
        hz.memtoregE = 1; hz.writeregE = 0; hz.rsD = 0;
        #1 chk("lw_r0_stallD", 32'(hz.stallD), 32'd0);

        // Branch stalls: ALU result in E, load in M
        clear_inputs();
        hz.branchD = 1; hz.rsD = 3; hz.regwriteE = 1; hz.writeregE = 3;
        #1 chk("br_E_stallD", 32'(hz.stallD), 32'd1);
        chk("br_E_flushE", 32'(hz.flushE), 32'd1);
        hz.regwriteE = 0; hz.memtoregM = 1; hz.writeregM = 4; hz.rtD = 4;
        #1 chk("br_M_stallD", 32'(hz.stallD), 32'd1);
        hz.branchD = 0;
        #1 chk("br_none_stallD", 32'(hz.stallD), 32'd0);

        // HI/LO read after mthi/mtlo in M: one stall cycle with bubble
        clear_inputs();
        tick();
        hz.hilo_readD = 1; hz.hilo_writeM = 1;
        #1 chk_stalls("hilo_M", 1'b1, 1'b0);
        chk("hilo_M_flushE", 32'(hz.flushE), 32'd1);
        tick();
        hz.hilo_writeM = 0;
        #1 chk("hilo_after_stallD", 32'(hz.stallD), 32'd0);
        chk("hilo_after_flushE", 32'(hz.flushE), 32'd0);

        // MDU op, MDU_CYCLES=4, with mfhi waiting in D
        clear_inputs();
        hz.mdu_startE = 1; hz.hilo_readD = 1;
        #1 chk_stalls("mdu_c1", 1'b1, 1'b1);
        chk("mdu_c1_busy", 32'(hz.mdu_busy), 32'd0);
        chk("mdu_c1_flushE", 32'(hz.flushE), 32'd0);
        tick();
        #1 chk_stalls("mdu_c2", 1'b1, 1'b1);
        chk("mdu_c2_busy", 32'(hz.mdu_busy), 32'd1);
        tick();
        // Load-use while E is frozen: D stays stalled, no bubble
        hz.memtoregE = 1; hz.writeregE = 8; hz.rsD = 8;
        #1 chk_stalls("mdu_c3", 1'b1, 1'b1);
        chk("mdu_c3_lw_flushE", 32'(hz.flushE), 32'd0);
        tick();
        hz.memtoregE = 0; hz.writeregE = 0; hz.rsD = 0;
        #1 chk_stalls("mdu_c4", 1'b1, 1'b1);
        chk("mdu_c4_done", 32'(hz.mdu_done), 32'd0);
        tick();
        #1 chk_stalls("mdu_done", 1'b0, 1'b0);
        chk("mdu_done_pulse", 32'(hz.mdu_done), 32'd1);
        chk("mdu_done_busy",  32'(hz.mdu_busy), 32'd1);
        tick();
        hz.mdu_startE = 0; hz.hilo_readD = 0;
        #1 chk("mdu_idle_busy", 32'(hz.mdu_busy), 32'd0);
        chk("mdu_idle_done", 32'(hz.mdu_done), 32'd0);
        chk("mdu_idle_stallE", 32'(hz.stallE), 32'd0);
        tick();

        // Exception in the second BUSY cycle
        hz.mdu_startE = 1;
        tick();
        tick();
        #1 chk("exc_pre_busy", 32'(hz.mdu_busy), 32'd1);
        hz.excM = 1;
        #1 chk_stalls("exc", 1'b0, 1'b0);
        chk("exc_flushF", 32'(hz.flushF), 32'd1);
        chk("exc_flushD", 32'(hz.flushD), 32'd1);
        chk("exc_flushE", 32'(hz.flushE), 32'd1);
        chk("exc_flushM", 32'(hz.flushM), 32'd1);
        chk("exc_flushW", 32'(hz.flushW), 32'd0);
        tick();
        hz.excM = 0; hz.mdu_startE = 0;
        #1 chk("exc_next_busy",  32'(hz.mdu_busy),  32'd0);
        chk("exc_next_abort", 32'(hz.mdu_abort), 32'd1);
        chk("exc_next_done",  32'(hz.mdu_done),  32'd0);
        tick();
        #1 chk("exc_abort_end", 32'(hz.mdu_abort), 32'd0);

        // Start together with exception: no transition
        hz.mdu_startE = 1; hz.excM = 1;
        #1 chk("excstart_stallE", 32'(hz.stallE), 32'd0);
        tick();
        hz.mdu_startE = 0; hz.excM = 0;
        #1 chk("excstart_busy",  32'(hz.mdu_busy),  32'd0);
        chk("excstart_abort", 32'(hz.mdu_abort), 32'd0);

        // Reset mid-BUSY: silent abandon
        hz.mdu_startE = 1;
        tick();
        tick();
        #1 chk("rstmid_pre_busy", 32'(hz.mdu_busy), 32'd1);
        resetn = 1'b0;
        tick();
        hz.mdu_startE = 0;
        #1 chk("rstmid_busy",   32'(hz.mdu_busy),  32'd0);
        chk("rstmid_abort",  32'(hz.mdu_abort), 32'd0);
        chk("rstmid_stallE", 32'(hz.stallE),    32'd0);
`ifdef HAZARD_PERF_EN
        chk("rstmid_perf_lw",  perf_lw_cnt,  32'd0);
        chk("rstmid_perf_br",  perf_br_cnt,  32'd0);
        chk("rstmid_perf_mdu", perf_mdu_cnt, 32'd0);
`endif
        resetn = 1'b1;
        tick();
        #1 chk("post_rst_busy", 32'(hz.mdu_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_sb.md
Name: hazard_sb

Overview:
- Next-generation hazard/forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Adds an internal multi-cycle MDU (mult/div) sequencer that replaces the external div_running input.
- Adds HI/LO read-after-write stalls, precise-exception flush, and parametrised register-address width and MDU latency.
- Sits beside the datapath and drives all stall, flush and forward selects.

Parameters:
- RA_W, 5, register address width; address 0 is hard-zero and is never forwarded or stalled on.
- MDU_CYCLES, 32, total stall cycles for one MDU operation; must be >= 2.
- CNT_W, 6, MDU counter width; must satisfy 2^CNT_W > MDU_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  synchronous, active-low reset
- rsD, rtD  in  RA_W  decode-stage source registers
- branchD  in  1  branch in D (compare resolved in D)
- hilo_readD  in  1  mfhi/mflo in D
- rsE, rtE, writeregE  in  RA_W  execute-stage register addresses
- regwriteE, memtoregE  in  1  execute-stage write and load flags
- mdu_startE  in  1  mult/div op present in E
- hilo_writeE, hilo_writeM  in  1  mthi/mtlo in E or M
- writeregM, writeregW  in  RA_W  destinations in M and W
- regwriteM, memtoregM, regwriteW  in  1  M/W write and load flags
- excM  in  1  exception committed in M
- forwardaD, forwardbD  out  1  D-stage compare source from M
- forwardaE, forwardbE  out  2  E-stage ALU source: 00 reg, 10 M, 01 W
- stallF, stallD, stallE, stallM, stallW  out  1  per-stage stalls
- flushF, flushD, flushE, flushM, flushW  out  1  per-stage flushes
- mdu_busy  out  1  MDU FSM is not IDLE
- mdu_done  out  1  one-cycle result-valid pulse
- mdu_abort  out  1  one-cycle cancel pulse to the MDU

Behaviour:
- Forwarding (combinational):
  - forwardaE/forwardbE select M when the E source is nonzero, equals writeregM and regwriteM is set; otherwise W under the same rule; otherwise 00. M has priority over W.
  - forwardaD/forwardbD are set when the D source is nonzero, equals writeregM and regwriteM is set.
- lwstall = memtoregE & writeregE!=0 & (writeregE==rsD | writeregE==rtD).
- brstall = branchD & ((regwriteE & writeregE!=0 & writeregE matches rsD/rtD) | (memtoregM & writeregM!=0 & writeregM matches rsD/rtD)).
- hilostall = hilo_readD & (hilo_writeE | hilo_writeM | mdu_stall).
- MDU FSM states: IDLE, BUSY, DONE.
  - IDLE & mdu_startE: go to BUSY and load cnt = MDU_CYCLES-2.
  - BUSY: cnt!=0 decrements cnt; cnt==0 goes to DONE.
  - DONE: always goes to IDLE. mdu_startE is ignored in DONE because the same op is still leaving E.
- mdu_stall = (IDLE & mdu_startE) | BUSY. This gives exactly MDU_CYCLES stall cycles, then one DONE cycle with mdu_done=1 in which E advances.
- mdu_busy = state != IDLE.
- Stall outputs:
  - stallF = stallD = lwstall | brstall | hilostall | mdu_stall.
  - stallE = stallM = stallW = mdu_stall.
- Flush outputs:
  - flushE = (lwstall | brstall | hilostall) & ~mdu_stall, which inserts a bubble.
  - flushF, flushD, flushM are 0 unless an exception is taken.
  - flushW is always 0.
- Exception (excM=1):
  - flushF, flushD, flushE and flushM are 1.
  - All stall outputs are forced to 0.
  - The FSM goes to IDLE next cycle. If the FSM was not IDLE, mdu_abort=1 in that cycle.
  - excM takes priority over every other condition.
- Reset (resetn=0 at a clock edge):
  - state=IDLE, cnt=0.
  - Registered outputs mdu_done=0, mdu_abort=0.
  - Reset mid-MDU abandons the operation silently, with no abort pulse.
  - Combinational outputs follow their inputs, with mdu_stall=0 while state is IDLE.
- Simultaneous events:
  - lwstall during BUSY: flushE stays 0 because E is frozen, and D stays stalled.
  - mdu_startE with excM: no transition occurs.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, three 32-bit outputs are added: perf_lw_cnt, perf_br_cnt, perf_mdu_cnt.
  - Each counts cycles in which its cause (lwstall, brstall, mdu_stall) is asserted.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined, the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- hazard_pkg holds:
  - Forward-select constants FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - MDU state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One sub-module, hazard_mdu_seq, holds the FSM, the counter, and the done/abort generation. It exports mdu_stall and mdu_busy.

Test Plan:
- rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardaE=10. With regwriteM=0 -> forwardaE=01. With rsE=0 -> 00.
- memtoregE=1, writeregE=8, rsD=8 -> stallF=stallD=1, flushE=1 for one cycle, then 0 once the load leaves E.
- mdu_startE held with MDU_CYCLES=4 -> stallE=1 for exactly 4 cycles, then mdu_done=1 for one cycle with stalls=0, then IDLE.
- hilo_readD=1 during an MDU op -> stallD stays 1 until the DONE cycle. hilo_readD with hilo_writeM=1 -> one stall cycle with flushE=1.
- excM=1 in the second BUSY cycle -> flushF/D/E/M=1, all stalls 0, mdu_abort pulse, next cycle mdu_busy=0.
- resetn=0 mid-BUSY -> next cycle mdu_busy=0, no abort pulse. With HAZARD_PERF_EN, counters read 0.
